// File: rtl/fixed_to_float.sv
// Sign/magnitude/fractional-count fixed-point to IEEE-754 single converter.
// Normalises one bit per cycle behind valid/ready handshakes on input and output.
module fixed_to_float (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign_in,
    input  logic [23:0] mag_in,
    input  logic [7:0]  frac_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        DONE
    } state_t;

    state_t      state;
    logic        sign_q;
    logic [23:0] sh;
    logic [4:0]  s;
    logic [7:0]  frac_q;
    logic signed [9:0] e;

    // Biased exponent once bit 23 is reached: 127 + 23 - shifts - fractional bits.
    always_comb begin
        e = 10'sd150 - $signed({5'b0, s}) - $signed({2'b0, frac_q});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            sign_q    <= 1'b0;
            sh        <= '0;
            s         <= '0;
            frac_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_q   <= sign_in;
                        sh       <= mag_in;
                        frac_q   <= frac_in;
                        s        <= '0;
                        in_ready <= 1'b0;
                        if (mag_in == '0) begin
                            result    <= {sign_in, 31'b0};
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (!sh[23]) begin
                        sh <= {sh[22:0], 1'b0};
                        s  <= s + 5'd1;
                    end else begin
                        // No denormals: anything below the normal range flushes to signed zero.
                        if (e <= 10'sd0)
                            result <= {sign_q, 31'b0};
                        else
                            result <= {sign_q, e[7:0], sh[22:0]};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_to_float.sv
// Scoreboard bench for fixed_to_float: directed corner cases plus random operands
// checked against an arithmetic model of the single-precision encoding.
module tb_fixed_to_float;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        sign_in;
    logic [23:0] mag_in;
    logic [7:0]  frac_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    fixed_to_float dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign_in   (sign_in),
        .mag_in    (mag_in),
        .frac_in   (frac_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;
    logic bp_mode = 1'b0;
    logic or_fixed = 1'b1;
    logic prev_ov = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) out_ready = bp_mode ? 1'($urandom_range(0, 1)) : or_fixed;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    // Value = (-1)^s * m / 2^f; normal float has exponent floor(log2(value)) + 127.
    function automatic logic [31:0] ref_res(input logic s, input logic [23:0] m, input logic [7:0] f);
        int          p;
        int          ex;
        logic [23:0] norm;
        logic [31:0] exv;
        if (m == 0) return {s, 31'b0};
        p = 0;
        for (int i = 0; i < 24; i++) if (m[i]) p = i;
        ex = 127 + p - int'(f);
        if (ex <= 0) return {s, 31'b0};
        norm = m << (23 - p);
        exv  = 32'(ex);
        return {s, exv[7:0], norm[22:0]};
    endfunction

    // Edges after the acceptance edge until out_valid is seen high.
    function automatic int ref_lat(input logic [23:0] m);
        int p;
        if (m == 0) return 0;
        p = 0;
        for (int i = 0; i < 24; i++) if (m[i]) p = i;
        return 1 + (23 - p);
    endfunction

    // Monitor: compares every cycle out_valid is high, pops on handoff.
    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            prev_ov = 1'b0;
        end else if (out_valid) begin
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_output: got 0x%08h, expected no output", result);
            end else begin
                if (!prev_ov) chk("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
                chk("result", result, q[0].res);
                if (out_ready) void'(q.pop_front());
            end
            prev_ov = !out_ready;
        end else begin
            prev_ov = 1'b0;
        end
    end

    task automatic send(input logic s, input logic [23:0] m, input logic [7:0] f, input logic hold);
        int   n;
        exp_t x;
        @(negedge clk);
        sign_in = s; mag_in = m; frac_in = f; in_valid = 1'b1;
        n = 0;
        while (!in_ready) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                n_total++;
                $display("FAIL accept_timeout: in_ready=%0d, expected 1", in_ready);
                in_valid = 1'b0;
                return;
            end
        end
        x.res = ref_res(s, m, f);
        x.lat = ref_lat(m);
        x.acc = cyc + 1;
        q.push_back(x);
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            n_total++;
            $display("FAIL drain_timeout: pending=%0d, expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; sign_in = 1'b0; mag_in = '0; frac_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_result", result, 32'h0);

        send(1'b0, 24'h000003, 8'd1, 1'b0);    drain();
        send(1'b1, 24'h800000, 8'd0, 1'b0);    drain();
        send(1'b1, 24'h000000, 8'd0, 1'b0);    drain();
        send(1'b0, 24'h000000, 8'd0, 1'b0);    drain();
        send(1'b0, 24'h000001, 8'd126, 1'b0);  drain();
        send(1'b0, 24'h000001, 8'd127, 1'b0);  drain();
        send(1'b0, 24'h000001, 8'd200, 1'b0);  drain();
        chk("ref_small", ref_res(1'b0, 24'h000003, 8'd1), 32'h3FC00000);
        chk("ref_boundary", ref_res(1'b0, 24'h000001, 8'd126), 32'h00800000);

        // Backpressure: consumer stalls while a new operand is offered continuously.
        or_fixed = 1'b0;
        send(1'b0, 24'h000400, 8'd10, 1'b1);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            mag_in = 24'($urandom); frac_in = 8'($urandom);
            n++;
        end
        repeat (5) begin
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
            mag_in = 24'($urandom); frac_in = 8'($urandom);
        end
        or_fixed = 1'b1;
        n = 0;
        while (out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        chk("bp_handoff", 32'(out_valid), 32'd0);
        drain();

        // Reset while normalising discards the operand.
        send(1'b0, 24'h000001, 8'd0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'h0);
        send(1'b0, 24'h000002, 8'd0, 1'b0);
        drain();

        // Random operands under random backpressure.
        bp_mode = 1'b1;
        for (int i = 0; i < 150; i++) begin
            logic [23:0] m;
            logic [7:0]  f;
            m = 24'($urandom >> $urandom_range(8, 31));
            if ($urandom_range(0, 9) == 0) m = '0;
            f = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 40));
            send(1'($urandom), m, f, 1'b0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        drain();
        bp_mode = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        n_total++;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "timeout");
    end

endmodule
